onehot_stream_mux: RTL

- Parametrised, registered N-channel stream multiplexer.
- A one-hot select steers one of `NUM_CH` valid/ready input streams onto a single registered output stream.
- Once a packet has started, the selection is locked until the beat carrying `last` is accepted.
- Sits between per-channel producers and a shared downstream consumer; it is the packet-aware, back-pressured generalisation of the team's 4:1 one-hot bit mux.

---
 rtl/onehot_stream_mux_pkg.sv | 14 +
 rtl/onehot_stream_mux_if.sv | 26 ++
 rtl/onehot_stream_mux_onehot_to_bin.sv | 14 +
 rtl/onehot_stream_mux.sv | 74 +++++++
 4 files changed

// File: rtl/onehot_stream_mux_pkg.sv
// onehot_stream_mux_pkg: shared types and one-hot helpers for the stream mux
// Contents: state_t (IDLE/BUSY), MAX_CH (widest supported channel count),
// is_onehot() and lowest_bit() operating on zero-extended MAX_CH-bit masks.
package onehot_stream_mux_pkg;
   localparam int MAX_CH = 32;
   typedef enum logic {IDLE, BUSY} state_t;
   function automatic logic is_onehot(logic [MAX_CH-1:0] v);
      return (v != '0) && ((v & (v - MAX_CH'(1))) == '0);
   endfunction
   // two's-complement trick isolates the lowest set bit
   function automatic logic [MAX_CH-1:0] lowest_bit(logic [MAX_CH-1:0] v);
      return v & (~v + MAX_CH'(1));
   endfunction
endpackage

// File: rtl/onehot_stream_mux_if.sv
// onehot_stream_mux_if: bundle of select, input streams, output stream and error
// slave: the mux side (drives in_ready_o, out_*_o, err_o)
// master: the environment side (drives sel_i, in_*_i, out_ready_i)
interface onehot_stream_mux_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
);
   logic [NUM_CH-1:0]        sel_i;
   logic [NUM_CH-1:0]        in_valid_i;
   logic [NUM_CH*DATA_W-1:0] in_data_i;
   logic [NUM_CH-1:0]        in_last_i;
   logic [NUM_CH-1:0]        in_ready_o;
   logic                     out_valid_o;
   logic [DATA_W-1:0]        out_data_o;
   logic                     out_last_o;
   logic                     out_ready_i;
   logic                     err_o;
   modport slave (
      input  sel_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_last_o, err_o
   );
   modport master (
      output sel_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_last_o, err_o
   );
endinterface

// File: rtl/onehot_stream_mux_onehot_to_bin.sv
// onehot_to_bin: converts a one-hot mask into its binary index
// Ports: onehot (NUM_CH-bit mask, at most one bit set), bin (index, 0 when mask is 0)
module onehot_to_bin #(
   parameter  int NUM_CH = 4,
   localparam int W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] onehot,
   output logic [W-1:0]      bin
);
   always_comb begin
      bin = '0;
      for (int k = 0; k < NUM_CH; k++) bin |= onehot[k] ? W'(k) : '0;
   end
endmodule

// File: rtl/onehot_stream_mux.sv
// onehot_stream_mux: packet-aware one-hot N:1 stream mux with registered output
// Ports: clk, reset (async, active-high), bus (onehot_stream_mux_if.slave):
//   sel_i one-hot select sampled in IDLE, in_valid_i/in_data_i/in_last_i/in_ready_o
//   per-channel input streams, out_valid_o/out_data_o/out_last_o/out_ready_i output
//   stream, err_o illegal-select pulse.
// Build option ONEHOT_STREAM_MUX_SEL_CHECK_EN: multi-hot select is rejected and
// flagged on err_o; otherwise it resolves to the lowest set channel.
module onehot_stream_mux
   import onehot_stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
) (
   input logic                clk,
   input logic                reset,
   onehot_stream_mux_if.slave bus
);
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   state_t            state_q, state_d;
   logic [NUM_CH-1:0] lock_q, lock_d, cand, grant;
   logic [IW-1:0]     idx;
   logic              slot_free, acc, beat_last;
   logic [DATA_W-1:0] beat_data;
`ifdef ONEHOT_STREAM_MUX_SEL_CHECK_EN
   logic bad_sel;
   assign bad_sel = (state_q == IDLE) && (bus.sel_i != '0) && !is_onehot(MAX_CH'(bus.sel_i));
   assign cand = bad_sel ? '0 : bus.sel_i;
   always_ff @(posedge clk or posedge reset)
      if (reset) bus.err_o <= 1'b0;
      else bus.err_o <= bad_sel;
`else
   assign cand = NUM_CH'(lowest_bit(MAX_CH'(bus.sel_i)));
   assign bus.err_o = 1'b0;
`endif
   assign slot_free = ~bus.out_valid_o | bus.out_ready_i;
   assign grant = (state_q == BUSY) ? lock_q : cand;
   // ready never looks at in_valid_i, so producers may wait on it freely
   assign bus.in_ready_o = reset ? '0 : grant & {NUM_CH{slot_free}};
   assign acc = |(bus.in_valid_i & bus.in_ready_o);
   onehot_to_bin #(.NUM_CH(NUM_CH)) u_bin (.onehot(grant), .bin(idx));
   assign beat_data = bus.in_data_i[int'(idx)*DATA_W +: DATA_W];
   assign beat_last = bus.in_last_i[idx];
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      if (acc && state_q == IDLE && !beat_last) begin
         state_d = BUSY;
         lock_d  = grant;
      end else if (acc && state_q == BUSY && beat_last) begin
         state_d = IDLE;
         lock_d  = '0;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bus.out_valid_o <= 1'b0;
         bus.out_data_o  <= '0;
         bus.out_last_o  <= 1'b0;
      end else if (acc) begin
         bus.out_valid_o <= 1'b1;
         bus.out_data_o  <= beat_data;
         bus.out_last_o  <= beat_last;
      end else if (bus.out_ready_i) begin
         bus.out_valid_o <= 1'b0;
      end
endmodule
